// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, H/V scan FSMs, sync/blank
// delay line aligned to the object/mux pipeline, and DAC colour out.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIX_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [7:0]         RGBin,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               pixelEn,
  output logic               startOfFrame,
  output logic               hSyncN,
  output logic               vSyncN,
  output logic               blankN,
  output logic [7:0]         vgaR,
  output logic [7:0]         vgaG,
  output logic [7:0]         vgaB
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int D = PIPE_DELAY - 1;
  localparam int DW =
    (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [10:0] H_VIS_END =
    11'(H_VISIBLE - 1);
  localparam logic [10:0] H_FP_END =
    11'(H_VISIBLE + H_FRONT - 1);
  localparam logic [10:0] H_SY_END =
    11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] H_TOT_END =
    11'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS_END =
    11'(V_VISIBLE - 1);
  localparam logic [10:0] V_FP_END =
    11'(V_VISIBLE + V_FRONT - 1);
  localparam logic [10:0] V_SY_END =
    11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] V_TOT_END =
    11'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_END =
    DW'(PIX_DIV - 1);

  typedef enum logic [1:0] {
    H_VIS, H_FP, H_SY, H_BP
  } h_state_t;

  typedef enum logic [1:0] {
    V_VIS, V_FP, V_SY, V_BP
  } v_state_t;

  logic [DW-1:0] divCnt;
  logic          run;
  logic [10:0]   hCount;
  logic [10:0]   vCount;
  h_state_t      h_state;
  h_state_t      h_next;
  v_state_t      v_state;
  v_state_t      v_next;
  logic          line_end;
  logic          raw_h;
  logic          raw_v;
  logic          h_vis;
  logic          v_vis;
  logic [2:0]    raw;
  logic [2:0]    aligned;

  // run masks pixelEn during the reset clock when PIX_DIV is 1
  always_ff @(posedge clk) begin
    if (!resetN) begin
      divCnt <= '0;
      run    <= 1'b0;
    end else begin
      run    <= 1'b1;
      divCnt <= (divCnt == DIV_END) ?
                '0 : divCnt + 1'b1;
    end
  end

  assign pixelEn  = run && (divCnt == DIV_END);
  assign line_end = pixelEn &&
                    (hCount == H_TOT_END);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      hCount <= '0;
    end else if (pixelEn) begin
      hCount <= (hCount == H_TOT_END) ?
                '0 : hCount + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      vCount <= '0;
    end else if (line_end) begin
      vCount <= (vCount == V_TOT_END) ?
                '0 : vCount + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) h_state <= H_VIS;
    else         h_state <= h_next;
  end

  always_comb begin
    h_next = h_state;
    if (pixelEn) begin
      unique case (h_state)
        H_VIS:
          if (hCount == H_VIS_END) h_next = H_FP;
        H_FP:
          if (hCount == H_FP_END)  h_next = H_SY;
        H_SY:
          if (hCount == H_SY_END)  h_next = H_BP;
        H_BP:
          if (hCount == H_TOT_END) h_next = H_VIS;
        default: h_next = H_VIS;
      endcase
    end
  end

  always_comb begin
    raw_h = 1'b1;
    h_vis = 1'b0;
    unique case (h_state)
      H_VIS:   h_vis = 1'b1;
      H_SY:    raw_h = 1'b0;
      default: raw_h = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) v_state <= V_VIS;
    else         v_state <= v_next;
  end

  always_comb begin
    v_next = v_state;
    if (line_end) begin
      unique case (v_state)
        V_VIS:
          if (vCount == V_VIS_END) v_next = V_FP;
        V_FP:
          if (vCount == V_FP_END)  v_next = V_SY;
        V_SY:
          if (vCount == V_SY_END)  v_next = V_BP;
        V_BP:
          if (vCount == V_TOT_END) v_next = V_VIS;
        default: v_next = V_VIS;
      endcase
    end
  end

  always_comb begin
    raw_v = 1'b1;
    v_vis = 1'b0;
    unique case (v_state)
      V_VIS:   v_vis = 1'b1;
      V_SY:    raw_v = 1'b0;
      default: raw_v = 1'b1;
    endcase
  end

  assign raw = {raw_h, raw_v, h_vis && v_vis};

  // {hSync, vSync, blank}; inactive pattern is 3'b110
  generate
    if (D == 0) begin : g_nodly
      assign aligned = raw;
    end else begin : g_dly
      logic [3*D-1:0] pipe_q;
      always_ff @(posedge clk) begin
        if (!resetN) begin
          pipe_q <= {D{3'b110}};
        end else if (pixelEn) begin
          pipe_q[2:0] <= raw;
          for (int i = 1; i < D; i++) begin
            pipe_q[3*i +: 3] <=
              pipe_q[3*(i-1) +: 3];
          end
        end
      end
      assign aligned = pipe_q[3*D-1 -: 3];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetN) begin
      hSyncN <= 1'b1;
      vSyncN <= 1'b1;
      blankN <= 1'b0;
      vgaR   <= '0;
      vgaG   <= '0;
      vgaB   <= '0;
    end else if (pixelEn) begin
      hSyncN <= aligned[2];
      vSyncN <= aligned[1];
      blankN <= aligned[0];
      if (aligned[0]) begin
        vgaR <= {RGBin[7:5], RGBin[7:5],
                 RGBin[7:6]};
        vgaG <= {RGBin[4:2], RGBin[4:2],
                 RGBin[4:3]};
        vgaB <= {RGBin[1:0], RGBin[1:0],
                 RGBin[1:0], RGBin[1:0]};
      end else begin
        vgaR <= '0;
        vgaG <= '0;
        vgaB <= '0;
      end
    end
  end

  assign startOfFrame = pixelEn &&
                        (hCount == '0) &&
                        (vCount == '0);

  assign pixelX = signed'(hCount);
  assign pixelY = signed'(vCount);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: random colour and
// resets checked each clk against a pixel-index model.
module tb_vga_timing_gen;

  localparam int HV = 20;
  localparam int HF = 3;
  localparam int HS = 4;
  localparam int HB = 5;
  localparam int VV = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int P  = 2;
  localparam int PD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic               clk;
  logic               resetN;
  logic [7:0]         RGBin;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic               pixelEn;
  logic               startOfFrame;
  logic               hSyncN;
  logic               vSyncN;
  logic               blankN;
  logic [7:0]         vgaR;
  logic [7:0]         vgaG;
  logic [7:0]         vgaB;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(P), .PIPE_DELAY(PD)
  ) dut (
    .clk(clk), .resetN(resetN), .RGBin(RGBin),
    .pixelX(pixelX), .pixelY(pixelY),
    .pixelEn(pixelEn),
    .startOfFrame(startOfFrame),
    .hSyncN(hSyncN), .vSyncN(vSyncN),
    .blankN(blankN),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand(
    input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = c[7:5];
    g = c[4:2];
    b = c[1:0];
    return {r, r, r[2:1], g, g, g[2:1],
            b, b, b, b};
  endfunction

  // model: c = clks since reset edge, pix = pixel ticks done
  int         c = 0;
  int         pix = 0;
  logic [7:0] last_rgb = '0;
  bit         armed = 0;

  always @(posedge clk) begin
    if (!resetN) begin
      c = 0;
      pix = 0;
      last_rgb = '0;
      armed = 1;
    end else begin
      if (c >= 1 && (c % P) == P - 1) begin
        pix++;
        last_rgb = RGBin;
      end
      c++;
    end
  end

  int         m_idx;
  int         m_xi;
  int         m_yi;
  logic       m_pen;
  logic       m_h;
  logic       m_v;
  logic       m_b;
  logic [23:0] m_rgb;

  always @(negedge clk) begin
    if (armed) begin
      m_pen = (c >= 1) && ((c % P) == P - 1);
      m_idx = pix - PD;
      if (m_idx < 0) begin
        m_h = 1'b1;
        m_v = 1'b1;
        m_b = 1'b0;
      end else begin
        m_xi = m_idx % HT;
        m_yi = (m_idx / HT) % VT;
        m_h = !(m_xi >= HV + HF &&
                m_xi < HV + HF + HS);
        m_v = !(m_yi >= VV + VF &&
                m_yi < VV + VF + VS);
        m_b = (m_xi < HV) && (m_yi < VV);
      end
      m_rgb = m_b ? expand(last_rgb) : 24'h0;
      chk("pixelEn", 32'(pixelEn), 32'(m_pen));
      chk("pixelX", 32'(pixelX), pix % HT);
      chk("pixelY", 32'(pixelY),
          (pix / HT) % VT);
      chk("startOfFrame", 32'(startOfFrame),
          32'(m_pen && pix % HT == 0 &&
              (pix / HT) % VT == 0));
      chk("hSyncN", 32'(hSyncN), 32'(m_h));
      chk("vSyncN", 32'(vSyncN), 32'(m_v));
      chk("blankN", 32'(blankN), 32'(m_b));
      chk("vgaRGB", {8'h0, vgaR, vgaG, vgaB},
          {8'h0, m_rgb});
    end
  end

  int  n;
  int  nb;
  int  nh;
  int  nv;
  bit  seen;

  initial begin
    resetN = 1'b0;
    RGBin  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixelX", 32'(pixelX), 0);
    chk("rst_pixelY", 32'(pixelY), 0);
    chk("rst_hSyncN", 32'(hSyncN), 1);
    chk("rst_blankN", 32'(blankN), 0);
    chk("rst_vgaR", 32'(vgaR), 0);
    chk("rst_sof", 32'(startOfFrame), 0);
    resetN = 1'b1;
    RGBin  = 8'h5B;
    @(negedge clk);
    chk("first_pen", 32'(pixelEn), 1);
    chk("first_sof", 32'(startOfFrame), 1);
    chk("first_x", 32'(pixelX), 0);
    @(negedge clk);
    chk("step_x", 32'(pixelX), 1);
    chk("step_pen", 32'(pixelEn), 0);

    n = 2; nb = 0; nh = 0; nv = 0; seen = 0;
    while (!startOfFrame && n < 5000) begin
      if (pixelEn) begin
        nb += int'(blankN);
        nh += int'(!hSyncN);
        nv += int'(!vSyncN);
        if (blankN && !seen) begin
          seen = 1;
          chk("lit_5B_R", 32'(vgaR), 32'h49);
          chk("lit_5B_G", 32'(vgaG), 32'hDB);
          chk("lit_5B_B", 32'(vgaB), 32'hFF);
        end
      end
      @(negedge clk);
      n++;
    end
    chk("frame_period", n - 1, 1216);
    chk("blank_ticks", nb, 240);
    chk("hsync_ticks", nh, 76);
    chk("vsync_ticks", nv, 64);

    RGBin = 8'hE0;
    repeat (10) @(negedge clk);
    n = 0;
    while (!(blankN && pixelEn) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("lit_E0_R", 32'(vgaR), 32'hFF);
    chk("lit_E0_G", 32'(vgaG), 32'h00);
    chk("lit_E0_B", 32'(vgaB), 32'h00);

    repeat (9000) begin
      @(negedge clk);
      RGBin  = 8'($urandom);
      resetN = ($urandom_range(0, 1499) != 0);
    end

    @(negedge clk);
    resetN = 1'b1;
    n = 0;
    while (!(pixelX == 11'sd10 &&
             pixelY == 11'sd5) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_found", 32'(n < 3000), 1);
    resetN = 1'b0;
    @(negedge clk);
    chk("mid_rst_x", 32'(pixelX), 0);
    chk("mid_rst_y", 32'(pixelY), 0);
    chk("mid_rst_pen", 32'(pixelEn), 0);
    chk("mid_rst_vs", 32'(vSyncN), 1);
    chk("mid_rst_vgaG", 32'(vgaG), 0);
    resetN = 1'b1;
    @(negedge clk);
    chk("mid_pen", 32'(pixelEn), 1);
    chk("mid_sof", 32'(startOfFrame), 1);
    @(negedge clk);
    chk("mid_x1", 32'(pixelX), 1);
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
